// File: rtl/floating_point_unit_pkg.sv
// Shared float32 types, rounding-mode codes and the rounding increment decoder.
//   float32_t       : {sign, exponent, mantissa}
//   round_bits_t    : {guard, round, sticky}
//   fflags_t        : {invalid, div_by_zero, overflow, underflow, inexact}
//   rounding_mode_t : RISC-V rm encodings
package floating_point_unit_pkg;

    localparam int unsigned EXP_W   = 8;
    localparam int unsigned MANT_W  = 23;
    localparam int unsigned MAG_W   = EXP_W + MANT_W;
    localparam int unsigned FLAGS_W = 5;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        DYN = 3'b111
    } rounding_mode_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exponent;
        logic [MANT_W-1:0] mantissa;
    } float32_t;

    typedef struct packed {
        logic guard;
        logic round;
        logic sticky;
    } round_bits_t;

    typedef struct packed {
        logic invalid;
        logic div_by_zero;
        logic overflow;
        logic underflow;
        logic inexact;
    } fflags_t;

    localparam logic [MAG_W-1:0] MAX_FINITE_MAGNITUDE = 31'h7F7FFFFF;
    localparam logic [EXP_W-1:0] EXP_ALL_ONES         = 8'hFF;
    localparam float32_t         CANONICAL_NAN        = 32'h7FC00000;

    // Decide whether the truncated magnitude must be bumped by one ulp.
    function automatic logic round_increment(
        input rounding_mode_t rm,
        input logic           sign,
        input logic           l,
        input logic           g,
        input logic           r,
        input logic           s
    );
        logic inc;
        inc = 1'b0;
        case (rm)
            RNE:     inc = g & (l | r | s);
            RTZ:     inc = 1'b0;
            RDN:     inc = sign & (g | r | s);
            RUP:     inc = ~sign & (g | r | s);
            RMM:     inc = g;
            default: inc = g & (l | r | s);
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/floating_point_rounding_unit.sv
// Two-stage IEEE-754 float32 rounding / exception stage.
// Stage 1 resolves the rounding mode and decides increment/inexact;
// stage 2 applies the increment, handles overflow and produces flags.
// Ports:
//   clk_i, clk_en_i, rst_n_i         : clock, global clock enable, async active-low reset
//   flush_i                          : kills both pipeline stages
//   data_valid_i, result_i,
//   round_bits_i                     : unrounded operand and its G/R/S bits
//   invalid_operation_i, divide_by_zero_i,
//   overflow_i, underflow_i          : upstream exception indications
//   instr_rm_i, frm_i                : static and dynamic rounding modes
//   fflags_clear_i                   : clears the accumulated flags
//   data_valid_o, result_o, fflags_o : rounded result and per-op flags
//   fflags_acc_o                     : sticky accumulated flags
//   illegal_rm_o                     : reserved rounding mode seen
module floating_point_rounding_unit
    import floating_point_unit_pkg::*;
(
    input  logic               clk_i,
    input  logic               clk_en_i,
    input  logic               rst_n_i,
    input  logic               flush_i,
    input  logic               data_valid_i,
    input  float32_t           result_i,
    input  round_bits_t        round_bits_i,
    input  logic               invalid_operation_i,
    input  logic               divide_by_zero_i,
    input  logic               overflow_i,
    input  logic               underflow_i,
    input  logic [2:0]         instr_rm_i,
    input  logic [2:0]         frm_i,
    input  logic               fflags_clear_i,
    output logic               data_valid_o,
    output float32_t           result_o,
    output logic [FLAGS_W-1:0] fflags_o,
    output logic [FLAGS_W-1:0] fflags_acc_o,
    output logic               illegal_rm_o
);

    // Stage-1 combinational decisions
    logic           rm_raw_c_is_dyn;
    logic [2:0]     rm_raw_c;
    logic           rm_illegal_c;
    rounding_mode_t rm_eff_c;
    logic           special_c;
    logic           inexact_c;
    logic           increment_c;

    // Stage-1 registers
    logic             s1_valid;
    logic             s1_sign;
    logic [MAG_W-1:0] s1_mag;
    logic             s1_finite;
    logic             s1_increment;
    logic             s1_inexact;
    rounding_mode_t   s1_rm;
    logic             s1_illegal;
    logic             s1_nv;
    logic             s1_dz;
    logic             s1_of;
    logic             s1_uf;

    // Stage-2 combinational results
    logic [MAG_W-1:0] sum_c;
    logic             overflow_c;
    logic             saturate_c;
    float32_t         rounded_c;
    fflags_t          flags_c;
    logic             exception_c;

    // Resolve the dynamic mode, then map reserved codes onto RNE.
    always_comb begin
        rm_raw_c_is_dyn = (instr_rm_i == 3'b111);
        rm_raw_c        = rm_raw_c_is_dyn ? frm_i : instr_rm_i;
        rm_illegal_c    = (rm_raw_c == 3'b101) || (rm_raw_c == 3'b110) || (rm_raw_c == 3'b111);
        rm_eff_c        = rm_illegal_c ? RNE : rounding_mode_t'(rm_raw_c);
    end

    // NaN and exact infinity pass through untouched.
    always_comb begin
        special_c   = (result_i.exponent == EXP_ALL_ONES) && !overflow_i;
        inexact_c   = !special_c && (round_bits_i.guard | round_bits_i.round | round_bits_i.sticky);
        increment_c = !special_c && round_increment(rm_eff_c, result_i.sign, result_i.mantissa[0],
                                                    round_bits_i.guard, round_bits_i.round,
                                                    round_bits_i.sticky);
    end

    // Stage 1 register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid     <= 1'b0;
            s1_sign      <= 1'b0;
            s1_mag       <= '0;
            s1_finite    <= 1'b0;
            s1_increment <= 1'b0;
            s1_inexact   <= 1'b0;
            s1_rm        <= RNE;
            s1_illegal   <= 1'b0;
            s1_nv        <= 1'b0;
            s1_dz        <= 1'b0;
            s1_of        <= 1'b0;
            s1_uf        <= 1'b0;
        end else if (clk_en_i) begin
            s1_valid <= data_valid_i && !flush_i;
            if (data_valid_i) begin
                s1_sign      <= result_i.sign;
                s1_mag       <= {result_i.exponent, result_i.mantissa};
                s1_finite    <= (result_i.exponent != EXP_ALL_ONES);
                s1_increment <= increment_c;
                s1_inexact   <= inexact_c;
                s1_rm        <= rm_eff_c;
                s1_illegal   <= rm_illegal_c;
                s1_nv        <= invalid_operation_i;
                s1_dz        <= divide_by_zero_i;
                s1_of        <= overflow_i;
                s1_uf        <= underflow_i;
            end
        end
    end

    // Mantissa carry ripples into the exponent, covering binade and
    // subnormal-to-normal transitions without special cases.
    always_comb begin
        sum_c       = s1_mag + MAG_W'(s1_increment);
        overflow_c  = s1_of || (s1_finite && (sum_c[MAG_W-1:MANT_W] == EXP_ALL_ONES));
        saturate_c  = (s1_rm == RTZ) || ((s1_rm == RDN) && !s1_sign) || ((s1_rm == RUP) && s1_sign);
        rounded_c   = {s1_sign, sum_c};
        if (overflow_c) begin
            rounded_c = saturate_c ? {s1_sign, MAX_FINITE_MAGNITUDE}
                                   : {s1_sign, EXP_ALL_ONES, MANT_W'(0)};
        end
        exception_c         = s1_nv || s1_dz;
        flags_c.invalid     = s1_nv;
        flags_c.div_by_zero = s1_dz;
        flags_c.overflow    = overflow_c && !exception_c;
        flags_c.underflow   = s1_uf && s1_inexact && !exception_c;
        flags_c.inexact     = (s1_inexact || overflow_c) && !exception_c;
    end

    // Stage 2 / output register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_valid_o <= 1'b0;
            result_o     <= '0;
            fflags_o     <= '0;
            illegal_rm_o <= 1'b0;
        end else if (clk_en_i) begin
            data_valid_o <= s1_valid && !flush_i;
            if (s1_valid) begin
                result_o     <= rounded_c;
                fflags_o     <= FLAGS_W'(flags_c);
                illegal_rm_o <= s1_illegal;
            end
        end
    end

    // Sticky flags: absorb the flags of each delivered result; a clear in the
    // same cycle keeps only that result's flags.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fflags_acc_o <= '0;
        end else if (clk_en_i) begin
            if (fflags_clear_i) begin
                fflags_acc_o <= data_valid_o ? fflags_o : FLAGS_W'(0);
            end else if (data_valid_o) begin
                fflags_acc_o <= fflags_acc_o | fflags_o;
            end
        end
    end

endmodule

// File: tb/tb_floating_point_rounding_unit.sv
`timescale 1ns/1ps
module tb_floating_point_rounding_unit;
    import floating_point_unit_pkg::*;

    logic        clk;
    logic        clk_en;
    logic        rst_n;
    logic        flush;
    logic        data_valid_in;
    float32_t    result_in;
    round_bits_t round_bits;
    logic        nv_in, dz_in, of_in, uf_in;
    logic [2:0]  instr_rm, frm;
    logic        fflags_clear;
    logic        data_valid_out;
    float32_t    result_out;
    logic [4:0]  fflags;
    logic [4:0]  fflags_acc;
    logic        illegal_rm;

    int errors = 0;
    int checks = 0;

    floating_point_rounding_unit dut (
        .clk_i               (clk),
        .clk_en_i            (clk_en),
        .rst_n_i             (rst_n),
        .flush_i             (flush),
        .data_valid_i        (data_valid_in),
        .result_i            (result_in),
        .round_bits_i        (round_bits),
        .invalid_operation_i (nv_in),
        .divide_by_zero_i    (dz_in),
        .overflow_i          (of_in),
        .underflow_i         (uf_in),
        .instr_rm_i          (instr_rm),
        .frm_i               (frm),
        .fflags_clear_i      (fflags_clear),
        .data_valid_o        (data_valid_out),
        .result_o            (result_out),
        .fflags_o            (fflags),
        .fflags_acc_o        (fflags_acc),
        .illegal_rm_o        (illegal_rm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [2:0]  grs;
        logic        nv, dz, of, uf;
        logic [2:0]  irm;
        logic [2:0]  frm;
        logic [31:0] exp_res;
        logic [4:0]  exp_flags;
        logic        exp_ill;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic [31:0] res, input logic [2:0] grs,
                                input logic nv, input logic dz, input logic of, input logic uf,
                                input logic [2:0] irm, input logic [2:0] f,
                                input logic [31:0] er, input logic [4:0] ef, input logic ei);
        vec_t v;
        v.res = res; v.grs = grs; v.nv = nv; v.dz = dz; v.of = of; v.uf = uf;
        v.irm = irm; v.frm = f; v.exp_res = er; v.exp_flags = ef; v.exp_ill = ei;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        result_in     = v.res;
        round_bits    = v.grs;
        nv_in         = v.nv;
        dz_in         = v.dz;
        of_in         = v.of;
        uf_in         = v.uf;
        instr_rm      = v.irm;
        frm           = v.frm;
        data_valid_in = 1'b1;
    endtask

    initial begin
        //                res           grs     nv dz of uf irm     frm     exp_res       flags     ill
        vecs[0]  = mk(32'h3F800001, 3'b100, 0, 0, 0, 0, 3'b000, 3'b000, 32'h3F800002, 5'b00001, 0);
        vecs[1]  = mk(32'h3F800000, 3'b100, 0, 0, 0, 0, 3'b000, 3'b000, 32'h3F800000, 5'b00001, 0);
        vecs[2]  = mk(32'h3FFFFFFF, 3'b001, 0, 0, 0, 0, 3'b011, 3'b000, 32'h40000000, 5'b00001, 0);
        vecs[3]  = mk(32'h7F7FFFFF, 3'b101, 0, 0, 0, 0, 3'b000, 3'b000, 32'h7F800000, 5'b00101, 0);
        vecs[4]  = mk(32'h7F800000, 3'b000, 0, 0, 1, 0, 3'b001, 3'b000, 32'h7F7FFFFF, 5'b00101, 0);
        vecs[5]  = mk(32'h7FC00000, 3'b111, 1, 0, 0, 0, 3'b000, 3'b000, 32'h7FC00000, 5'b10000, 0);
        vecs[6]  = mk(32'hFF800000, 3'b000, 0, 1, 0, 0, 3'b000, 3'b000, 32'hFF800000, 5'b01000, 0);
        vecs[7]  = mk(32'hBF800000, 3'b001, 0, 0, 0, 0, 3'b111, 3'b010, 32'hBF800001, 5'b00001, 0);
        vecs[8]  = mk(32'h3F800001, 3'b100, 0, 0, 0, 0, 3'b111, 3'b101, 32'h3F800002, 5'b00001, 1);
        vecs[9]  = mk(32'h00000001, 3'b110, 0, 0, 0, 1, 3'b000, 3'b000, 32'h00000002, 5'b00011, 0);
        vecs[10] = mk(32'h3F800000, 3'b100, 0, 0, 0, 0, 3'b100, 3'b000, 32'h3F800001, 5'b00001, 0);
        vecs[11] = mk(32'h3F800001, 3'b111, 0, 0, 0, 0, 3'b001, 3'b000, 32'h3F800001, 5'b00001, 0);
        vecs[12] = mk(32'h7F800000, 3'b000, 0, 0, 1, 0, 3'b010, 3'b000, 32'h7F7FFFFF, 5'b00101, 0);
        vecs[13] = mk(32'hFF800000, 3'b000, 0, 0, 1, 0, 3'b011, 3'b000, 32'hFF7FFFFF, 5'b00101, 0);
        vecs[14] = mk(32'hFF800000, 3'b000, 0, 0, 1, 0, 3'b010, 3'b000, 32'hFF800000, 5'b00101, 0);
        vecs[15] = mk(32'h3F800000, 3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 32'h3F800000, 5'b00000, 0);
        vecs[16] = mk(32'h00000001, 3'b000, 0, 0, 0, 1, 3'b000, 3'b000, 32'h00000001, 5'b00000, 0);
        vecs[17] = mk(32'h3F800000, 3'b110, 0, 0, 0, 0, 3'b101, 3'b000, 32'h3F800001, 5'b00001, 1);
        vecs[18] = mk(32'h3F800000, 3'b100, 1, 0, 0, 0, 3'b000, 3'b000, 32'h3F800000, 5'b10000, 0);
        vecs[19] = mk(32'h007FFFFF, 3'b100, 0, 0, 0, 1, 3'b000, 3'b000, 32'h00800000, 5'b00011, 0);

        clk_en = 1'b1; rst_n = 1'b0; flush = 1'b0; fflags_clear = 1'b0;
        data_valid_in = 1'b0; result_in = '0; round_bits = '0;
        nv_in = 0; dz_in = 0; of_in = 0; uf_in = 0; instr_rm = 3'b000; frm = 3'b000;

        #12;
        check("reset_valid", 32'(data_valid_out), 32'd0);
        check("reset_result", result_out, 32'd0);
        check("reset_flags", 32'(fflags), 32'd0);
        check("reset_acc", 32'(fflags_acc), 32'd0);
        check("reset_illegal", 32'(illegal_rm), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        tick();

        // Table: each vector alone, checking latency and values
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i]);
            tick();
            data_valid_in = 1'b0;
            check($sformatf("v%0d_lat1_valid", i), 32'(data_valid_out), 32'd0);
            tick();
            check($sformatf("v%0d_valid", i), 32'(data_valid_out), 32'd1);
            check($sformatf("v%0d_result", i), result_out, vecs[i].exp_res);
            check($sformatf("v%0d_fflags", i), 32'(fflags), 32'(vecs[i].exp_flags));
            check($sformatf("v%0d_illegal", i), 32'(illegal_rm), 32'(vecs[i].exp_ill));
        end
        tick();

        // Accumulator: clear, then three back-to-back operations
        fflags_clear = 1'b1;
        tick();
        fflags_clear = 1'b0;
        check("acc_cleared", 32'(fflags_acc), 32'd0);
        drive(vecs[5]);  tick();
        drive(vecs[6]);  tick();
        check("b2b_0_valid", 32'(data_valid_out), 32'd1);
        check("b2b_0_flags", 32'(fflags), 32'b10000);
        check("b2b_0_acc", 32'(fflags_acc), 32'd0);
        drive(vecs[3]);  tick();
        data_valid_in = 1'b0;
        check("b2b_1_flags", 32'(fflags), 32'b01000);
        check("b2b_1_acc", 32'(fflags_acc), 32'b10000);
        tick();
        check("b2b_2_valid", 32'(data_valid_out), 32'd1);
        check("b2b_2_result", result_out, 32'h7F800000);
        check("b2b_2_acc", 32'(fflags_acc), 32'b11000);
        tick();
        check("b2b_end_valid", 32'(data_valid_out), 32'd0);
        check("b2b_end_acc", 32'(fflags_acc), 32'b11101);

        // Clear coinciding with a valid output keeps only that output's flags
        drive(vecs[0]); tick();
        data_valid_in = 1'b0; tick();
        check("clr_valid", 32'(data_valid_out), 32'd1);
        fflags_clear = 1'b1;
        tick();
        fflags_clear = 1'b0;
        check("clr_acc", 32'(fflags_acc), 32'b00001);

        // Flush with two operations in flight
        drive(vecs[3]); tick();
        drive(vecs[6]); flush = 1'b1; tick();
        data_valid_in = 1'b0; flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("flush_valid_%0d", i), 32'(data_valid_out), 32'd0);
            tick();
        end
        check("flush_acc_kept", 32'(fflags_acc), 32'b00001);

        // Clock enable low freezes an in-flight operation
        drive(vecs[2]); tick();
        data_valid_in = 1'b0; clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("clken_hold_%0d", i), 32'(data_valid_out), 32'd0);
        end
        clk_en = 1'b1;
        tick();
        check("clken_valid", 32'(data_valid_out), 32'd1);
        check("clken_result", result_out, 32'h40000000);
        tick();

        // Asynchronous reset between edges with operations in flight
        drive(vecs[0]); tick();
        drive(vecs[3]); tick();
        data_valid_in = 1'b0;
        check("pre_rst_valid", 32'(data_valid_out), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(data_valid_out), 32'd0);
        check("arst_result", result_out, 32'd0);
        check("arst_flags", 32'(fflags), 32'd0);
        check("arst_acc", 32'(fflags_acc), 32'd0);
        check("arst_illegal", 32'(illegal_rm), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("arst_dropped_%0d", i), 32'(data_valid_out), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/floating_point_rounding_unit.md
Name: floating_point_rounding_unit

Overview:
- Two-stage pipelined rounding/exception stage placed directly downstream of the FP divider (and of the other FP arithmetic submodules).
- Consumes an unrounded float32 result, its guard/round/sticky bits and the raw exception indications.
- Produces the IEEE-754 correctly rounded result for the active RISC-V rounding mode, the per-operation fflags, and a sticky accumulated fflags register.

Parameters:
- None. Width is fixed to float32.

Ports:
- clk_i  input  1  core clock
- clk_en_i  input  1  clock enable (FPGA builds only); when low, all registers hold
- rst_n_i  input  1  asynchronous active-low reset
- flush_i  input  1  kills both pipeline stages synchronously
- data_valid_i  input  1  operand valid
- result_i  input  32 (float32_t)  unrounded result
- round_bits_i  input  3 (round_bits_t)  guard/round/sticky
- invalid_operation_i  input  1  NV request from upstream
- divide_by_zero_i  input  1  DZ request
- overflow_i  input  1  upstream exponent overflow; result_i is infinity
- underflow_i  input  1  upstream tiny result; result_i is subnormal or zero
- instr_rm_i  input  3  instruction rounding mode
- frm_i  input  3  CSR dynamic rounding mode
- fflags_clear_i  input  1  clears the accumulated flags
- data_valid_o  output  1  rounded result valid
- result_o  output  32 (float32_t)  rounded result
- fflags_o  output  5  per-operation flags {NV,DZ,OF,UF,NX}
- fflags_acc_o  output  5  accumulated flags
- illegal_rm_o  output  1  reserved rounding mode used; qualified by data_valid_o

Behaviour:
- Reset values: all outputs and registers are 0. Reset is asynchronous and active-low.
- Latency is exactly 2 cycles, fully pipelined. One operation per cycle is accepted with no back-pressure.
- Rounding mode: rm = (instr_rm_i == 3'b111) ? frm_i : instr_rm_i.
- Codes: RNE 000, RTZ 001, RDN 010, RUP 011, RMM 100.
- Reserved codes (101, 110, and DYN resolving to 101/110/111) are rounded as RNE and set illegal_rm_o.
- Stage 1 registers the inputs and the resolved rm. It computes:
  - inexact = G|R|S
  - increment, where L = mantissa[0]:
    - RNE: G&(L|R|S)
    - RTZ: 0
    - RDN: sign&inexact
    - RUP: ~sign&inexact
    - RMM: G
- Stage 2 computes {exponent, mantissa} + increment as a 31-bit add. Mantissa carry propagates into the exponent, so subnormal-to-normal and binade crossings need no special case.
- Special passthrough: if result_i.exponent == 8'hFF and overflow_i == 0 (NaN or exact infinity), force increment = 0 and inexact = 0. The result is passed unchanged.
- Overflow occurs when overflow_i is set, or when the post-increment exponent equals 8'hFF from a finite input. Output:
  - max finite (sign, 8'hFE, all-ones mantissa) for RTZ, for RDN with a positive sign, and for RUP with a negative sign;
  - otherwise sign-preserving infinity.
- Overflow sets OF and NX.
- Flags:
  - NV = invalid_operation_i
  - DZ = divide_by_zero_i
  - OF as above
  - UF = underflow_i & inexact
  - NX = inexact | OF
  - When NV or DZ is set, OF, UF and NX are forced to 0.
- Accumulator: on each data_valid_o, fflags_acc_o |= fflags_o.
  - fflags_clear_i alone sets the accumulator to 0.
  - fflags_clear_i in the same cycle as data_valid_o makes the accumulator equal that cycle's fflags_o.
- flush_i clears both stage valid bits in the next cycle. Data registers may hold stale values. fflags_acc_o is unaffected.
- Asynchronous reset mid-operation drops all in-flight operations. No data_valid_o is produced for them.
- clk_en_i low freezes the pipeline, including the valids and the accumulator.

Decomposition:
- floating_point_unit_pkg receives:
  - rounding_mode_t enum (RNE, RTZ, RDN, RUP, RMM, DYN)
  - fflags_t packed struct {invalid, div_by_zero, overflow, underflow, inexact}
  - constant MAX_FINITE_MAGNITUDE = 31'h7F7FFFFF
- round_bits_t, float32_t and CANONICAL_NAN are reused from the package.
- No sub-module. The increment decoder is a small package function, round_increment(rm, sign, L, G, R, S).

Test Plan:
- RNE ties: 0x3F800001, GRS=100 → 0x3F800002, NX. 0x3F800000, GRS=100 → 0x3F800000, NX. Both with data_valid_o exactly 2 cycles after input.
- Carry into exponent: 0x3FFFFFFF, GRS=001, rm=RUP → 0x40000000, fflags=00001.
- Overflow: 0x7F7FFFFF, GRS=101, RNE → 0x7F800000, fflags=00101. Input 0x7F800000 with overflow_i=1, RTZ → 0x7F7FFFFF, fflags=00101.
- Special passthrough: 0x7FC00000, invalid_operation_i=1, GRS=111 → 0x7FC00000, fflags=10000. Input 0xFF800000 with divide_by_zero_i=1 → 0xFF800000, fflags=01000.
- Dynamic mode and reserved mode:
  - instr_rm=111, frm=RDN, 0xBF800000, GRS=001 → 0xBF800001.
  - frm=101 → RNE result with illegal_rm_o=1.
  - Subnormal 0x00000001, underflow_i=1, GRS=110, RNE → 0x00000002, fflags=00011.
- Back-to-back, flush and reset:
  - Back-to-back inputs over 3 consecutive cycles accumulate fflags_acc_o. A clear coinciding with a valid output leaves only that output's flags.
  - flush_i with two operations in flight → no data_valid_o.
  - rst_n_i asserted asynchronously between clock edges → all outputs 0 immediately.
